// File: rtl/rv_pkg.sv
// Constants shared across the fetch path.
package rv_pkg;
    localparam int unsigned XLEN      = 64;
    localparam int unsigned ILEN      = 32;
    localparam logic [63:0] RESET_PC  = 64'h0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; the head is read straight from storage,
// so it is valid in the cycle after the push that wrote it.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so the head reads zero until first written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    assert property (@(posedge clk) disable iff (rst) !(pop_i && count_q == '0));
    assert property (@(posedge clk) disable iff (rst) !(push_i && count_q == CW'(DEPTH)));
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues word-aligned imem requests under a credit limit, queues
// returned words with their PC, and squashes in-flight responses on redirect.
module instr_fetch #(
    parameter int unsigned     XLEN     = rv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(rv_pkg::RESET_PC),
    parameter int unsigned     DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc
);
    import rv_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned QW = ILEN + XLEN;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   squash_q, squash_d;
    logic [CW-1:0]   q_count, tag_count;
    logic [XLEN-1:0] tag_pc;
    logic [QW-1:0]   q_head;
    logic            req_fire, resp_keep, out_fire;

    // Credit rule: queued plus in-flight never exceeds DEPTH, so the queue cannot overflow.
    assign imem_req_valid = !reset &&
                            (({1'b0, q_count} + {1'b0, inflight_q}) < (CW + 1)'(DEPTH));
    assign imem_addr      = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign out_valid = (q_count != '0);
    assign out_fire  = out_valid && out_ready;
    assign out_instr = q_head[QW-1 -: ILEN];
    assign out_pc    = q_head[XLEN-1:0];

    assign resp_keep = imem_resp_valid && (squash_q == '0) && !redirect_valid;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid)
            pc_d = redirect_pc & ~XLEN'(3);
        else if (req_fire)
            pc_d = pc_q + XLEN'(4);

        inflight_d = inflight_q + CW'(req_fire) - CW'(imem_resp_valid);

        // On redirect everything still outstanding after this cycle belongs to the old path.
        squash_d = squash_q;
        if (redirect_valid)
            squash_d = inflight_d;
        else if (imem_resp_valid && squash_q != '0)
            squash_d = squash_q - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            squash_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            squash_q   <= squash_d;
        end
    end

    fetch_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_instr_q (
        .clk         (clk),
        .rst         (reset),
        .flush_i     (redirect_valid),
        .push_i      (resp_keep),
        .push_data_i ({imem_resp_data, tag_pc}),
        .pop_i       (out_fire),
        .head_o      (q_head),
        .count_o     (q_count)
    );

    // Tags track every accepted request, squashed or not, so they stay aligned with responses.
    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
        .clk         (clk),
        .rst         (reset),
        .flush_i     (1'b0),
        .push_i      (req_fire),
        .push_data_i (pc_q),
        .pop_i       (imem_resp_valid),
        .head_o      (tag_pc),
        .count_o     (tag_count)
    );

    assert property (@(posedge clk) disable iff (reset) inflight_q == tag_count);
    assert property (@(posedge clk) disable iff (reset) squash_q <= inflight_q);
    assert property (@(posedge clk) disable iff (reset) !(imem_resp_valid && inflight_q == '0));
endmodule
